// File: rtl/kernel_cu_sync_pkg.sv
// Shared state encoding and constants for the kernel compute-unit sync block.
package kernel_cu_sync_pkg;

    typedef enum logic [2:0] {
        CU_SYNC_RESET,
        IDLE,
        SETUP,
        BUSY,
        FLUSH,
        DONE
    } cu_sync_state_t;

    localparam int CU_SYNC_FLUSH_DEFAULT = 8;

    // Flush counter only has to reach FLUSH_CYCLES-1; keep at least one bit.
    function automatic int flush_cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/kernel_cu_sync_if.sv
// Control/descriptor and per-CU handshake bundle between kernel control, the CUs and kernel_cu_sync.
interface kernel_cu_sync_if #(
    parameter int NUM_CUS = 4,
    parameter int CNT_W   = 32
);
    logic               ctrl_start;
    logic               descriptor_valid;
    logic [CNT_W-1:0]   descriptor_count;
    logic [NUM_CUS-1:0] cu_setup_req;
    logic [NUM_CUS-1:0] cu_setup_ack;
    logic [NUM_CUS-1:0] cu_done_valid;
    logic               cu_flush;
    logic               ctrl_setup;
    logic               ctrl_done;
    logic [CNT_W-1:0]   items_done;
    logic               wdog_timeout;

    modport master (
        output ctrl_start, descriptor_valid, descriptor_count, cu_setup_ack, cu_done_valid,
        input  cu_setup_req, cu_flush, ctrl_setup, ctrl_done, items_done, wdog_timeout
    );

    modport slave (
        input  ctrl_start, descriptor_valid, descriptor_count, cu_setup_ack, cu_done_valid,
        output cu_setup_req, cu_flush, ctrl_setup, ctrl_done, items_done, wdog_timeout
    );
endinterface

// File: rtl/kernel_cu_sync_cu_done_counter.sv
// Popcount of per-CU done pulses into a saturating item counter; count is registered, reached
// reflects the value being loaded this cycle. No backpressure: every enabled pulse is absorbed.
module cu_done_counter #(
    parameter int NUM_CUS = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [NUM_CUS-1:0] done_valid,
    input  logic [CNT_W-1:0]   target,
    output logic [CNT_W-1:0]   count,
    output logic               reached
);
    localparam int PopW = $clog2(NUM_CUS + 1);

    logic [PopW-1:0]  pop;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CUS; i++) begin
            pop = pop + PopW'(done_valid[i]);
        end
    end

    // One extra sum bit so a burst near the top of the range clamps instead of wrapping.
    always_comb begin
        sum        = {1'b0, count} + (CNT_W + 1)'(pop);
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (enable) begin
            count_next = (sum > {1'b0, target}) ? target : sum[CNT_W-1:0];
        end
    end

    assign reached = (count_next >= target);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/kernel_cu_sync.sv
// Kernel CU sync: CU setup handshake, completion counting, flush window, done hold; outputs registered, FSM reacts in one cycle.
// Optional watchdog under KERNEL_CU_SYNC_WATCHDOG_EN; without it SETUP/BUSY may wait indefinitely.
module kernel_cu_sync
    import kernel_cu_sync_pkg::*;
#(
    parameter int NUM_CUS      = 4,
    parameter int CNT_W        = 32,
    parameter int FLUSH_CYCLES = CU_SYNC_FLUSH_DEFAULT
`ifdef KERNEL_CU_SYNC_WATCHDOG_EN
    , parameter int WDOG_W     = 24
`endif
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    kernel_cu_sync_if.slave  bus
);
    localparam int                FlushW    = flush_cnt_width(FLUSH_CYCLES);
    localparam logic [FlushW-1:0] FlushLast = FlushW'(FLUSH_CYCLES - 1);

    cu_sync_state_t     state;
    logic               rst_q;
    logic               dv_q;
    logic [CNT_W-1:0]   target;
    logic [NUM_CUS-1:0] ack_mask;
    logic [NUM_CUS-1:0] setup_req;
    logic [FlushW-1:0]  flush_cnt;
    logic               flush_q;
    logic               setup_q;
    logic               done_q;
    logic [CNT_W-1:0]   items;
    logic               in_run;
    logic               start_cond;
    logic               abort;
    logic               all_acked;
    logic               count_en;
    logic               reached;
    logic               wdog_fire;

    always_ff @(posedge ap_clk) begin
        rst_q <= ap_rst_n;
    end

    assign in_run     = (state == SETUP) || (state == BUSY);
    assign start_cond = (state == IDLE) && bus.descriptor_valid && !dv_q && bus.ctrl_start;
    // Both levels were high on entry, so any low level here means one of them has fallen.
    assign abort      = (in_run || (state == FLUSH)) && !(bus.ctrl_start && bus.descriptor_valid);
    assign all_acked  = &(ack_mask | bus.cu_setup_ack);
    assign count_en   = !abort && ((state == BUSY) || ((state == SETUP) && all_acked));

    cu_done_counter #(
        .NUM_CUS (NUM_CUS),
        .CNT_W   (CNT_W)
    ) u_done_counter (
        .clk        (ap_clk),
        .rst_n      (rst_q),
        .clear      (start_cond),
        .enable     (count_en),
        .done_valid (bus.cu_done_valid),
        .target     (target),
        .count      (items),
        .reached    (reached)
    );

    always_ff @(posedge ap_clk) begin
        if (!rst_q) begin
            state     <= CU_SYNC_RESET;
            dv_q      <= 1'b0;
            target    <= '0;
            ack_mask  <= '0;
            setup_req <= '0;
            flush_cnt <= '0;
            flush_q   <= 1'b0;
            setup_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            dv_q <= bus.descriptor_valid;
            case (state)
                CU_SYNC_RESET: state <= IDLE;
                IDLE: begin
                    if (start_cond) begin
                        target    <= bus.descriptor_count;
                        ack_mask  <= '0;
                        setup_req <= '1;
                        setup_q   <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP, BUSY: begin
                    if (abort) begin
                        setup_req <= '0;
                        setup_q   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        setup_req <= setup_req & ~bus.cu_setup_ack;
                        ack_mask  <= ack_mask | bus.cu_setup_ack;
                        if (wdog_fire || (((state == BUSY) || all_acked) && reached)) begin
                            flush_cnt <= '0;
                            flush_q   <= 1'b1;
                            state     <= FLUSH;
                        end else if ((state == SETUP) && all_acked) begin
                            state <= BUSY;
                        end
                    end
                end
                FLUSH: begin
                    if (abort) begin
                        flush_q <= 1'b0;
                        setup_q <= 1'b1;
                        state   <= IDLE;
                    end else if (flush_cnt == FlushLast) begin
                        flush_q <= 1'b0;
                        done_q  <= 1'b1;
                        setup_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        flush_cnt <= flush_cnt + FlushW'(1);
                    end
                end
                DONE: begin
                    if (!bus.ctrl_start) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KERNEL_CU_SYNC_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_q;
    logic              wdog_event;

    assign wdog_event = (|bus.cu_setup_ack) || (|bus.cu_done_valid);
    // Fire on the step onto all-ones so the timeout is visible right after 2^WDOG_W-1 quiet cycles.
    assign wdog_fire  = in_run && !wdog_event && (wdog_cnt == ~WDOG_W'(1));

    always_ff @(posedge ap_clk) begin
        if (!rst_q) begin
            wdog_cnt <= '0;
            wdog_q   <= 1'b0;
        end else begin
            if (!in_run || wdog_event) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end
            if (wdog_fire) begin
                wdog_q <= 1'b1;
            end
        end
    end

    assign bus.wdog_timeout = wdog_q;
`else
    assign wdog_fire        = 1'b0;
    assign bus.wdog_timeout = 1'b0;
`endif

    assign bus.cu_setup_req = setup_req;
    assign bus.cu_flush     = flush_q;
    assign bus.ctrl_setup   = setup_q;
    assign bus.ctrl_done    = done_q;
    assign bus.items_done   = items;

endmodule

// File: tb/tb_kernel_cu_sync.sv
// Directed-plus-random bench for kernel_cu_sync; reference is an item-count/latency model derived from the behavioural rules.
module tb_kernel_cu_sync;
    localparam int NCU = 4;
    localparam int CW  = 32;
    localparam int FL  = 8;

    logic ap_clk;
    logic ap_rst_n;
    int   checks;
    int   failures;
    int unsigned m_target;
    int unsigned m_items;

    kernel_cu_sync_if #(.NUM_CUS(NCU), .CNT_W(CW)) intf ();

    kernel_cu_sync #(
        .NUM_CUS      (NCU),
        .CNT_W        (CW),
        .FLUSH_CYCLES (FL)
`ifdef KERNEL_CU_SYNC_WATCHDOG_EN
        , .WDOG_W     (4)
`endif
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (intf)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NCU-1:0] pulse_for(input int mode);
        logic [NCU-1:0] p;
        case (mode)
            0: p = ($urandom_range(0, 3) == 0) ? '0 : NCU'(1 << $urandom_range(0, NCU - 1));
            1: p = NCU'($urandom_range(0, 2**NCU - 1));
            default: p = '1;
        endcase
        return p;
    endfunction

    // Items accumulate by the number of set bits and never exceed the latched count.
    task automatic model_add(input logic [NCU-1:0] p);
        if (m_items + $countones(p) > m_target) m_items = m_target;
        else m_items = m_items + $countones(p);
    endtask

    task automatic do_start(input int unsigned cnt);
        logic [NCU-1:0] all;
        all = '1;
        intf.descriptor_count = cnt;
        intf.descriptor_valid = 1'b1;
        intf.ctrl_start       = 1'b1;
        tick();
        m_target = cnt;
        m_items  = 0;
        chk("req_after_start", intf.cu_setup_req, all);
        chk("setup_after_start", intf.ctrl_setup, 1'b0);
        chk("items_cleared", intf.items_done, 0);
    endtask

    // Acks spread over three cycles, with repeats on CUs that already acked; pulses only on the final ack cycle.
    task automatic do_acks(input int mode);
        int ack_at [NCU];
        logic [NCU-1:0] acked, ack, p, exp_req;
        acked = '0;
        foreach (ack_at[i]) ack_at[i] = $urandom_range(0, 2);
        ack_at[$urandom_range(0, NCU - 1)] = 2;
        for (int c = 0; c < 3; c++) begin
            ack = acked & NCU'($urandom_range(0, 2**NCU - 1));
            for (int i = 0; i < NCU; i++) if (ack_at[i] == c) ack[i] = 1'b1;
            p = '0;
            if (c == 2 && mode != 0) p = pulse_for(mode);
            if (c == 2) model_add(p);
            intf.cu_setup_ack  = ack;
            intf.cu_done_valid = p;
            tick();
            acked   = acked | ack;
            exp_req = ~acked;
            chk("setup_req", intf.cu_setup_req, exp_req);
            chk("setup_low_in_run", intf.ctrl_setup, 1'b0);
        end
        intf.cu_setup_ack  = '0;
        intf.cu_done_valid = '0;
        chk("items_last_ack", intf.items_done, m_items);
        chk("flush_last_ack", intf.cu_flush, m_items >= m_target);
    endtask

    task automatic count_phase(input int mode, input int unsigned stop_at);
        logic [NCU-1:0] p;
        int guard;
        guard = 0;
        while (m_items < m_target && m_items < stop_at && guard < 500) begin
            p = pulse_for(mode);
            intf.cu_done_valid = p;
            model_add(p);
            tick();
            guard++;
            chk("items_busy", intf.items_done, m_items);
            chk("flush_busy", intf.cu_flush, m_items >= m_target);
        end
        intf.cu_done_valid = '0;
    endtask

    task automatic release_run();
        intf.ctrl_start       = 1'b0;
        intf.descriptor_valid = 1'b0;
        intf.cu_done_valid    = '0;
        tick();
        chk("done_cleared", intf.ctrl_done, 1'b0);
        chk("setup_idle", intf.ctrl_setup, 1'b1);
        chk("flush_idle", intf.cu_flush, 1'b0);
    endtask

    // Latency counted from the tick that sampled the final counted item; flush pulses must be ignored.
    task automatic finish_phase();
        int lat, fl;
        lat = 1;
        fl  = 1;
        while (!intf.ctrl_done && lat < 40) begin
            intf.cu_done_valid = NCU'($urandom_range(0, 2**NCU - 1));
            tick();
            lat++;
            if (intf.cu_flush) fl++;
        end
        intf.cu_done_valid = '0;
        chk("done_latency", lat, FL + 1);
        chk("flush_len", fl, FL);
        chk("items_final", intf.items_done, m_target);
        chk("setup_in_done", intf.ctrl_setup, 1'b1);
        chk("wdog_quiet", intf.wdog_timeout, 1'b0);
        release_run();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_setup"}, intf.ctrl_setup, 1'b1);
        chk({tag, "_done"}, intf.ctrl_done, 1'b0);
        chk({tag, "_req"}, intf.cu_setup_req, 0);
        chk({tag, "_items"}, intf.items_done, 0);
        chk({tag, "_flush"}, intf.cu_flush, 1'b0);
        chk({tag, "_wdog"}, intf.wdog_timeout, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_target = 0;
        m_items  = 0;
        ap_rst_n              = 1'b0;
        intf.ctrl_start       = 1'b0;
        intf.descriptor_valid = 1'b0;
        intf.descriptor_count = '0;
        intf.cu_setup_ack     = '0;
        intf.cu_done_valid    = '0;

        repeat (5) tick();
        check_reset_values("reset");
        ap_rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_setup", intf.ctrl_setup, 1'b1);

        // Normal run with single pulses, then a 4-wide burst that overshoots, then a zero count.
        do_start(10); do_acks(0); count_phase(0, 32'hFFFF_FFFF); finish_phase();
        do_start(5);  do_acks(2); count_phase(2, 32'hFFFF_FFFF); finish_phase();
        do_start(0);  do_acks(1); count_phase(1, 32'hFFFF_FFFF); finish_phase();

        for (int r = 0; r < 4; r++) begin
            int md;
            md = $urandom_range(0, 2);
            do_start($urandom_range(1, 40)); do_acks(md); count_phase(md, 32'hFFFF_FFFF); finish_phase();
        end

        // Abort mid-BUSY: back to IDLE, count kept and frozen.
        do_start(20); do_acks(0); count_phase(0, 3);
        intf.ctrl_start = 1'b0;
        tick();
        chk("abort_setup", intf.ctrl_setup, 1'b1);
        chk("abort_done", intf.ctrl_done, 1'b0);
        chk("abort_req", intf.cu_setup_req, 0);
        chk("abort_flush", intf.cu_flush, 1'b0);
        chk("abort_items", intf.items_done, 3);
        intf.cu_done_valid = '1;
        repeat (2) tick();
        chk("idle_ignores_done", intf.items_done, 3);
        release_run();

        // Reset in the middle of BUSY.
        do_start(10); do_acks(0); count_phase(0, 4);
        ap_rst_n = 1'b0;
        repeat (5) tick();
        check_reset_values("midreset");
        intf.ctrl_start       = 1'b0;
        intf.descriptor_valid = 1'b0;
        ap_rst_n = 1'b1;
        repeat (3) tick();

        do_start(7); do_acks(1); count_phase(1, 32'hFFFF_FFFF); finish_phase();

`ifdef KERNEL_CU_SYNC_WATCHDOG_EN
        begin
            int idle, lat;
            do_start(10); do_acks(0); count_phase(0, 2);
            idle = 0;
            while (!intf.wdog_timeout && idle < 40) begin
                tick();
                idle++;
            end
            chk("wdog_idle_cycles", idle, 15);
            chk("wdog_flush", intf.cu_flush, 1'b1);
            lat = 0;
            while (!intf.ctrl_done && lat < 40) begin
                tick();
                lat++;
            end
            chk("wdog_done_latency", lat, FL);
            chk("wdog_items", intf.items_done, 2);
            chk("wdog_sticky", intf.wdog_timeout, 1'b1);
            release_run();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
